// File: rtl/system_memory_v5_if.sv
// Bus bundle for system_memory_v5: parallel grid load, serial load and
// serial readout with its valid/ready handshake, plus status outputs.
interface system_memory_v5_if #(
   parameter int DATA_SIZE = 64,
   parameter int LANES     = 1
);
   localparam int BEATS = DATA_SIZE / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [DATA_SIZE-1:0] grid_in;
   logic                 run_mode;
   logic                 load_mode;
   logic [LANES-1:0]     serial_in;
   logic                 serial_in_valid;
   logic                 output_mode;
   logic                 serial_out_ready;
   logic [DATA_SIZE-1:0] system_mem_out;
   logic [LANES-1:0]     serial_out;
   logic                 serial_out_valid;
   logic                 busy;
   logic                 frame_done;
   logic [CW-1:0]        beat_count;

   // Driving side: the serial interface / grid calculator environment
   modport master (
      output grid_in, run_mode, load_mode, serial_in, serial_in_valid,
             output_mode, serial_out_ready,
      input  system_mem_out, serial_out, serial_out_valid, busy,
             frame_done, beat_count
   );

   // Memory side
   modport slave (
      input  grid_in, run_mode, load_mode, serial_in, serial_in_valid,
             output_mode, serial_out_ready,
      output system_mem_out, serial_out, serial_out_valid, busy,
             frame_done, beat_count
   );
endinterface

// File: rtl/system_memory_v5.sv
// Multi-lane grid frame memory. Stores one DATA_SIZE-bit frame, loads it
// in parallel from the grid calculator or serially LANES bits per beat,
// and reads it out serially as a rotation so the contents survive a
// complete readout unchanged.
module system_memory_v5 #(
   parameter int DATA_SIZE = 64,
   parameter int LANES     = 1
) (
   input  logic                clk,
   input  logic                reset,
   system_memory_v5_if.slave   bus
);
   localparam int BEATS = DATA_SIZE / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   // A lane width that does not divide the frame would leave a ragged
   // final beat, so refuse to elaborate rather than silently truncate.
   if ((DATA_SIZE % LANES) != 0) begin : g_badLanes
      $error("system_memory_v5: DATA_SIZE must be a multiple of LANES");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic [DATA_SIZE-1:0] r_mem;
   logic [DATA_SIZE-1:0] w_nextMem;
   logic [CW-1:0]        r_count;
   logic [CW-1:0]        w_nextCount;
   logic                 r_frameDone;
   logic                 w_nextFrameDone;

   logic                 w_loadBeat;
   logic                 w_lastBeat;
   logic [DATA_SIZE-1:0] w_shiftLoad;
   logic [DATA_SIZE-1:0] w_rotate;

   // Shift/rotate are written as shifts rather than part-selects so the
   // LANES == DATA_SIZE case needs no special handling.
   assign w_loadBeat  = bus.load_mode & bus.serial_in_valid;
   assign w_lastBeat  = (r_count == LAST_BEAT);
   assign w_shiftLoad = (r_mem << LANES) | DATA_SIZE'(bus.serial_in);
   assign w_rotate    = (r_mem << LANES) | DATA_SIZE'(r_mem[DATA_SIZE-1 -: LANES]);

   // Next-state logic: run_mode beats a serial beat beats a readout
   // request in IDLE; OUT ignores every mode input so a frame is atomic.
   always_comb begin
      w_nextState     = r_state;
      w_nextMem       = r_mem;
      w_nextCount     = r_count;
      w_nextFrameDone = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.run_mode) begin
               w_nextMem   = bus.grid_in;
               w_nextCount = '0;
            end else if (w_loadBeat) begin
               w_nextMem = w_shiftLoad;
               if (w_lastBeat) begin
                  w_nextCount     = '0;
                  w_nextFrameDone = 1'b1;
                  w_nextState     = IDLE;
               end else begin
                  w_nextCount = r_count + 1'b1;
                  w_nextState = LOAD;
               end
            end else if (bus.output_mode) begin
               w_nextState = OUT;
            end
         end
         LOAD: begin
            if (bus.run_mode) begin
               w_nextMem   = bus.grid_in;
               w_nextCount = '0;
               w_nextState = IDLE;
            end else if (w_loadBeat) begin
               w_nextMem = w_shiftLoad;
               if (w_lastBeat) begin
                  w_nextCount     = '0;
                  w_nextFrameDone = 1'b1;
                  w_nextState     = IDLE;
               end else begin
                  w_nextCount = r_count + 1'b1;
               end
            end
         end
         OUT: begin
            if (bus.serial_out_ready) begin
               w_nextMem = w_rotate;
               if (w_lastBeat) begin
                  w_nextCount     = '0;
                  w_nextFrameDone = 1'b1;
                  w_nextState     = IDLE;
               end else begin
                  w_nextCount = r_count + 1'b1;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCount = '0;
         end
      endcase
   end

   // State, memory, beat counter and done pulse registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_mem       <= '0;
         r_count     <= '0;
         r_frameDone <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_mem       <= w_nextMem;
         r_count     <= w_nextCount;
         r_frameDone <= w_nextFrameDone;
      end
   end

   assign bus.system_mem_out   = r_mem;
   assign bus.serial_out       = (r_state == OUT) ? r_mem[DATA_SIZE-1 -: LANES] : '0;
   assign bus.serial_out_valid = (r_state == OUT);
   assign bus.busy             = (r_state != IDLE);
   assign bus.frame_done       = r_frameDone;
   assign bus.beat_count       = r_count;
endmodule

// File: tb/tb_system_memory_v5.sv
// Directed bench for system_memory_v5 at DATA_SIZE=8, LANES=2: a vector
// table walks serial load, readout, backpressure and abort cases, then a
// hand-written sequence exercises asynchronous reset mid-readout.
module tb_system_memory_v5;
   localparam int DS = 8;
   localparam int LN = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic       run;
      logic       load;
      logic       valid;
      logic [1:0] sin;
      logic       outMode;
      logic       ready;
      logic [7:0] grid;
      logic [7:0] expMem;
      logic [1:0] expSout;
      logic       expSval;
      logic       expBusy;
      logic       expDone;
      logic [1:0] expCnt;
   } vec_t;

   vec_t vecs[$];

   system_memory_v5_if #(.DATA_SIZE(DS), .LANES(LN)) bus ();

   system_memory_v5 #(.DATA_SIZE(DS), .LANES(LN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Watchdog so a stuck run still ends with a visible failure
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void addVec(
      input logic run, input logic load, input logic valid, input logic [1:0] sin,
      input logic outMode, input logic ready, input logic [7:0] grid,
      input logic [7:0] expMem, input logic [1:0] expSout, input logic expSval,
      input logic expBusy, input logic expDone, input logic [1:0] expCnt);
      vec_t v;
      v.run = run; v.load = load; v.valid = valid; v.sin = sin;
      v.outMode = outMode; v.ready = ready; v.grid = grid;
      v.expMem = expMem; v.expSout = expSout; v.expSval = expSval;
      v.expBusy = expBusy; v.expDone = expDone; v.expCnt = expCnt;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input vec_t v);
      bus.run_mode         = v.run;
      bus.load_mode        = v.load;
      bus.serial_in_valid  = v.valid;
      bus.serial_in        = v.sin;
      bus.output_mode      = v.outMode;
      bus.serial_out_ready = v.ready;
      bus.grid_in          = v.grid;
   endtask

   task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] mem, input logic [1:0] sout,
                              input logic sval, input logic busy, input logic done,
                              input logic [1:0] cnt);
      checkField({tag, ".mem"},   bus.system_mem_out,        mem);
      checkField({tag, ".sout"},  8'(bus.serial_out),        8'(sout));
      checkField({tag, ".sval"},  8'(bus.serial_out_valid),  8'(sval));
      checkField({tag, ".busy"},  8'(bus.busy),              8'(busy));
      checkField({tag, ".done"},  8'(bus.frame_done),        8'(done));
      checkField({tag, ".cnt"},   8'(bus.beat_count),        8'(cnt));
   endtask

   task automatic idleInputs();
      vec_t v;
      v = '{default: '0};
      applyStimulus(v);
   endtask

   initial begin
      vec_t v;
      bit   seenDone;

      //        run ld  vl sin    om rdy grid   | mem    sout  sv bz dn cnt
      // serial load of A5 with a valid gap
      addVec(0, 1, 1, 2'b10, 0, 0, 8'h00,  8'h02, 2'b00, 0, 1, 0, 2'd1);
      addVec(0, 1, 1, 2'b10, 0, 0, 8'h00,  8'h0A, 2'b00, 0, 1, 0, 2'd2);
      addVec(0, 1, 0, 2'b11, 0, 0, 8'h00,  8'h0A, 2'b00, 0, 1, 0, 2'd2);
      addVec(0, 1, 1, 2'b01, 0, 0, 8'h00,  8'h29, 2'b00, 0, 1, 0, 2'd3);
      addVec(0, 1, 1, 2'b01, 0, 0, 8'h00,  8'hA5, 2'b00, 0, 0, 1, 2'd0);
      addVec(0, 0, 0, 2'b00, 0, 0, 8'h00,  8'hA5, 2'b00, 0, 0, 0, 2'd0);
      // readout with ready high, output_mode and run_mode ignored mid-frame
      addVec(0, 0, 0, 2'b00, 1, 1, 8'h00,  8'hA5, 2'b10, 1, 1, 0, 2'd0);
      addVec(0, 0, 0, 2'b00, 0, 1, 8'h00,  8'h96, 2'b10, 1, 1, 0, 2'd1);
      addVec(0, 0, 0, 2'b00, 1, 1, 8'h00,  8'h5A, 2'b01, 1, 1, 0, 2'd2);
      addVec(1, 0, 0, 2'b00, 0, 1, 8'hFF,  8'h69, 2'b01, 1, 1, 0, 2'd3);
      addVec(0, 0, 0, 2'b00, 0, 1, 8'h00,  8'hA5, 2'b00, 0, 0, 1, 2'd0);
      addVec(0, 0, 0, 2'b00, 0, 0, 8'h00,  8'hA5, 2'b00, 0, 0, 0, 2'd0);
      // readout with three backpressure cycles
      addVec(0, 0, 0, 2'b00, 1, 0, 8'h00,  8'hA5, 2'b10, 1, 1, 0, 2'd0);
      addVec(0, 0, 0, 2'b00, 0, 1, 8'h00,  8'h96, 2'b10, 1, 1, 0, 2'd1);
      addVec(0, 0, 0, 2'b00, 0, 1, 8'h00,  8'h5A, 2'b01, 1, 1, 0, 2'd2);
      addVec(0, 0, 0, 2'b00, 0, 0, 8'h00,  8'h5A, 2'b01, 1, 1, 0, 2'd2);
      addVec(0, 0, 0, 2'b00, 0, 0, 8'h00,  8'h5A, 2'b01, 1, 1, 0, 2'd2);
      addVec(0, 0, 0, 2'b00, 0, 0, 8'h00,  8'h5A, 2'b01, 1, 1, 0, 2'd2);
      addVec(0, 0, 0, 2'b00, 0, 1, 8'h00,  8'h69, 2'b01, 1, 1, 0, 2'd3);
      addVec(0, 0, 0, 2'b00, 0, 1, 8'h00,  8'hA5, 2'b00, 0, 0, 1, 2'd0);
      addVec(0, 0, 0, 2'b00, 0, 0, 8'h00,  8'hA5, 2'b00, 0, 0, 0, 2'd0);
      // load aborted by run_mode after two beats
      addVec(0, 1, 1, 2'b11, 0, 0, 8'h00,  8'h97, 2'b00, 0, 1, 0, 2'd1);
      addVec(0, 1, 1, 2'b00, 0, 0, 8'h00,  8'h5C, 2'b00, 0, 1, 0, 2'd2);
      addVec(1, 1, 1, 2'b11, 0, 0, 8'h3C,  8'h3C, 2'b00, 0, 0, 0, 2'd0);
      addVec(0, 0, 0, 2'b00, 0, 0, 8'h00,  8'h3C, 2'b00, 0, 0, 0, 2'd0);
      // parallel load wins over a simultaneous beat in IDLE
      addVec(1, 1, 1, 2'b11, 0, 0, 8'hC3,  8'hC3, 2'b00, 0, 0, 0, 2'd0);
      // output_mode ignored in LOAD, partial frame held, then aborted
      addVec(0, 1, 1, 2'b10, 0, 0, 8'h00,  8'h0E, 2'b00, 0, 1, 0, 2'd1);
      addVec(0, 1, 0, 2'b00, 1, 0, 8'h00,  8'h0E, 2'b00, 0, 1, 0, 2'd1);
      addVec(1, 0, 0, 2'b00, 0, 0, 8'h00,  8'h00, 2'b00, 0, 0, 0, 2'd0);

      // Reset with all inputs low
      idleInputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);

      // Table-driven vectors, one clock edge each
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d", i), vecs[i].expMem, vecs[i].expSout,
                     vecs[i].expSval, vecs[i].expBusy, vecs[i].expDone, vecs[i].expCnt);
      end

      // Asynchronous reset in the middle of a readout
      v = '{default: '0};
      v.run = 1'b1; v.grid = 8'hA5;
      applyStimulus(v);
      @(posedge clk); #1;
      checkOutput("arst.load", 8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);
      v = '{default: '0};
      v.outMode = 1'b1;
      applyStimulus(v);
      @(posedge clk); #1;
      v.outMode = 1'b0; v.ready = 1'b1;
      applyStimulus(v);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("arst.mid", 8'h5A, 2'b01, 1'b1, 1'b1, 1'b0, 2'd2);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("arst.now", 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Next readout after the reset must stream zeros
      v = '{default: '0};
      v.outMode = 1'b1; v.ready = 1'b1;
      applyStimulus(v);
      @(posedge clk); #1;
      checkOutput("zero.start", 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 2'd0);
      v.outMode = 1'b0;
      applyStimulus(v);
      seenDone = 1'b0;
      for (int c = 0; c < 10 && !seenDone; c++) begin
         @(posedge clk); #1;
         if (bus.frame_done === 1'b1) begin
            seenDone = 1'b1;
         end else begin
            checkField($sformatf("zero.beat%0d", c), 8'(bus.serial_out), 8'h00);
         end
      end
      checkField("zero.done", 8'(seenDone), 8'h01);
      checkOutput("zero.end", 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0);
      idleInputs();
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/system_memory_v5.md
# system_memory_v5

Parametrised, multi-lane successor to the system grid memory. Holds one DATA_SIZE-bit grid frame and supports three activities: a parallel load from the grid calculator, a serial load over a LANES-bit input, and a serial readout over a LANES-bit output with a valid/ready handshake. Readout is frame-atomic: once started, it always rotates the memory through a whole frame, so the memory holds its original contents at the end and never ends up jumbled. It sits between the external serial interface and the grid calculator, in the same position as the previous memory generations.

## Interface
- DATA_SIZE, 64, grid bits stored.
- LANES, 1, bits moved per serial beat. DATA_SIZE % LANES must equal 0; elaboration fails otherwise.
- BEATS (localparam) = DATA_SIZE/LANES.
- CW (localparam) = max(1, $clog2(BEATS)).
- clk  in  1  system clock; everything is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- grid_in  in  DATA_SIZE  next grid from the calculator.
- run_mode  in  1  load grid_in in parallel.
- load_mode  in  1  serial load enabled.
- serial_in  in  LANES  serial load data, most-significant beat first.
- serial_in_valid  in  1  serial_in carries a beat.
- output_mode  in  1  request a serial frame readout.
- serial_out_ready  in  1  the downstream side accepts the current beat.
- system_mem_out  out  DATA_SIZE  memory contents; reset value 0.
- serial_out  out  LANES  top LANES bits of memory while in OUT, otherwise 0; reset value 0.
- serial_out_valid  out  1  high exactly while in OUT; reset value 0.
- busy  out  1  state is LOAD or OUT; reset value 0.
- frame_done  out  1  one-cycle pulse when a full frame has been loaded or sent; reset value 0.
- beat_count  out  CW  beats completed in the current frame; reset value 0.

## Operation
- States: IDLE, LOAD, OUT. Reset puts the block in IDLE with memory 0 and count 0.
- Transitions out of IDLE, highest priority first:
  - run_mode: mem <= grid_in; stay in IDLE.
  - load_mode & serial_in_valid: shift in the first beat and go to LOAD.
  - output_mode: go to OUT; memory is unchanged on this edge.
- Serial-load beat, in IDLE or LOAD:
  - Condition: load_mode & serial_in_valid.
  - mem <= {mem[DATA_SIZE-LANES-1:0], serial_in}; count increments.
  - The beat that completes the frame (count was BEATS-1) sets count to 0, pulses frame_done and goes to IDLE.
- LOAD with load_mode low or serial_in_valid low: hold memory, count and state; the partial frame is kept.
- LOAD with run_mode high: abort the frame. mem <= grid_in, count <= 0, go to IDLE, no frame_done pulse. run_mode always wins.
- LOAD with output_mode high: ignored.
- OUT:
  - serial_out = mem[DATA_SIZE-1 -: LANES] and serial_out_valid = 1.
  - A beat transfers on serial_out_ready.
  - On each transfer: mem <= {mem[DATA_SIZE-LANES-1:0], mem[DATA_SIZE-1 -: LANES]} (left rotate by LANES); count increments.
  - The final transfer sets count to 0, pulses frame_done and goes to IDLE. After it, memory equals its contents at entry to OUT.
  - run_mode, load_mode and output_mode are all ignored while in OUT; the frame cannot be aborted except by reset.
  - While serial_out_ready is low, serial_out and memory hold.
- Reset asserted at any time, including mid-frame: all outputs return to their reset values immediately (asynchronous), and the partial frame is discarded.

## Timing
- Parallel load: system_mem_out shows grid_in one edge after run_mode is sampled.
- Serial load of BEATS beats with valid held high: frame_done is high in the cycle after the last edge, BEATS edges after the first beat.
- Readout:
  - serial_out_valid rises one edge after output_mode is sampled in IDLE.
  - With ready held high, valid stays high for exactly BEATS cycles, then falls in the same edge that raises frame_done.
  - Each low-ready cycle extends the frame by one cycle.
- output_mode held high after a frame: a new readout starts on the edge after returning to IDLE, unless run_mode or a load beat takes precedence on that edge.
- Simultaneous run_mode and load beat in IDLE: the parallel load wins and the serial beat is dropped.

## Test plan
- Reset: release reset with all inputs 0 -> all outputs 0, state IDLE, busy 0.
- Serial load (DATA_SIZE=8, LANES=2): beats 2'b10, 2'b10, 2'b01, 2'b01 with valid high -> system_mem_out=8'hA5, one frame_done pulse, busy 0. Inserting valid gaps gives the same result.
- Readout with ready held high (mem=8'hA5): pulse output_mode -> serial_out beats 10, 10, 01, 01 on four consecutive valid cycles; frame_done pulses; mem=8'hA5 afterwards; output_mode toggling mid-frame has no effect.
- Readout with backpressure: ready low for 3 cycles in the middle of beat 2 -> serial_out holds 2'b01 and memory holds; the frame completes in 7 cycles with the same beat sequence.
- Abort and priority:
  - run_mode (grid_in=8'h3C) asserted after 2 load beats -> mem=8'h3C, count 0, no frame_done.
  - run_mode asserted during OUT -> ignored; readout completes intact.
- Asynchronous reset asserted mid-readout (after beat 2) -> outputs 0 immediately without waiting for a clock edge; the next output request reads all zeros.
